// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 2-flop synchroniser, 3-sample majority voting,
// optional parity and second stop bit, with per-frame error and break reporting.
module uart_rx_cfg #(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN_S,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [3:0]            DATA_LEN,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_W-1:0]     RX_OUT_P,
    output logic                  RX_OUT_V,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BRK_DET,
    output logic                  BUSY
);
    localparam int unsigned IdxW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2, StWaitHigh
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rxs;
    logic [PRESCALE_W-1:0] cnt_q, pre_q, half, pre_clamped;
    logic [IdxW-1:0]       bit_idx_q, len_q, len_clamped;
    logic [DATA_W-1:0]     data_q;
    logic                  par_en_q, par_typ_q, stop2_q;
    logic                  smp_a_q, smp_b_q, maj, decide, bit_end, start_det;
    logic                  par_err_q, stp_err_q, any_one_q;
    logic                  fin, brk, done_q, brk_q;

    always_comb begin
        if (DATA_LEN < 4'd5) begin
            len_clamped = IdxW'(5);
        end else if (32'(DATA_LEN) > DATA_W) begin
            len_clamped = IdxW'(DATA_W);
        end else begin
            len_clamped = IdxW'(DATA_LEN);
        end
    end

    assign pre_clamped = (Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : Prescale;
    assign half        = pre_q >> 1;
    assign decide      = (cnt_q == half + PRESCALE_W'(1));
    assign bit_end     = (cnt_q == pre_q - PRESCALE_W'(1));
    assign maj         = (smp_a_q & smp_b_q) | (smp_a_q & rxs) | (smp_b_q & rxs);
    assign start_det   = (state_q == StIdle) && !rxs;
    // Break means every bit after the start bit, including the final stop bit, was 0.
    assign brk         = !any_one_q && !maj;
    assign BUSY        = (state_q != StIdle);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN_S;
            rxs       <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fin     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rxs) state_d = StStart;
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && (bit_idx_q == len_q - IdxW'(1))) begin
                    state_d = par_en_q ? StParity : StStop1;
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop1;
            end
            StStop1: begin
                if (!stop2_q && decide) begin
                    fin     = 1'b1;
                    state_d = brk ? StWaitHigh : StIdle;
                end else if (stop2_q && bit_end) begin
                    state_d = StStop2;
                end
            end
            StStop2: begin
                if (decide) begin
                    fin     = 1'b1;
                    state_d = brk ? StWaitHigh : StIdle;
                end
            end
            StWaitHigh: begin
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            pre_q     <= PRESCALE_W'(4);
            len_q     <= IdxW'(5);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            bit_idx_q <= '0;
            data_q    <= '0;
            smp_a_q   <= 1'b1;
            smp_b_q   <= 1'b1;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            any_one_q <= 1'b0;
            done_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            done_q <= fin;
            brk_q  <= fin && brk;
            if (start_det) begin
                cnt_q     <= '0;
                pre_q     <= pre_clamped;
                len_q     <= len_clamped;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                stop2_q   <= STOP2;
                bit_idx_q <= '0;
                data_q    <= '0;
                par_err_q <= 1'b0;
                stp_err_q <= 1'b0;
                any_one_q <= 1'b0;
            end else if (state_q != StIdle && state_q != StWaitHigh) begin
                cnt_q <= bit_end ? '0 : cnt_q + PRESCALE_W'(1);
            end
            if (cnt_q == half - PRESCALE_W'(1)) smp_a_q <= rxs;
            if (cnt_q == half) smp_b_q <= rxs;
            if (decide) begin
                case (state_q)
                    StData: begin
                        data_q[bit_idx_q] <= maj;
                        any_one_q         <= any_one_q | maj;
                    end
                    StParity: begin
                        par_err_q <= (maj != (^data_q ^ par_typ_q));
                        any_one_q <= any_one_q | maj;
                    end
                    StStop1, StStop2: begin
                        stp_err_q <= stp_err_q | !maj;
                        any_one_q <= any_one_q | maj;
                    end
                    default: ;
                endcase
            end
            if (state_q == StData && bit_end) bit_idx_q <= bit_idx_q + IdxW'(1);
        end
    end

    // Outcome is reported one cycle after the final decision, from the settled flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RX_OUT_P <= '0;
            RX_OUT_V <= 1'b0;
            PAR_ERR  <= 1'b0;
            STP_ERR  <= 1'b0;
            BRK_DET  <= 1'b0;
        end else begin
            RX_OUT_V <= done_q && !brk_q && !par_err_q && !stp_err_q;
            PAR_ERR  <= done_q && !brk_q && par_err_q;
            STP_ERR  <= done_q && !brk_q && stp_err_q;
            BRK_DET  <= done_q && brk_q;
            if (done_q) RX_OUT_P <= data_q;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are driven bit-by-bit and expected outcomes
// queued, then matched against the one-cycle status pulses.
module tb_uart_rx_cfg;
    localparam int DW = 9;
    localparam int PW = 6;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b1;
    logic          RX_IN_S  = 1'b1;
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
    logic          STOP2    = 1'b0;
    logic [3:0]    DATA_LEN = 4'd8;
    logic [PW-1:0] Prescale = 6'd8;
    logic [DW-1:0] RX_OUT_P;
    logic          RX_OUT_V, PAR_ERR, STP_ERR, BRK_DET, BUSY;

    typedef struct {
        logic [3:0]    flags;  // {RX_OUT_V, PAR_ERR, STP_ERR, BRK_DET}
        logic [DW-1:0] data;
        int            e0;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    uart_rx_cfg #(.DATA_W(DW), .PRESCALE_W(PW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN_S  (RX_IN_S),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .STOP2    (STOP2),
        .DATA_LEN (DATA_LEN),
        .Prescale (Prescale),
        .RX_OUT_P (RX_OUT_P),
        .RX_OUT_V (RX_OUT_V),
        .PAR_ERR  (PAR_ERR),
        .STP_ERR  (STP_ERR),
        .BRK_DET  (BRK_DET),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (RX_OUT_V || PAR_ERR || STP_ERR || BRK_DET)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 32'({RX_OUT_V, PAR_ERR, STP_ERR, BRK_DET}), 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("flags", 32'({RX_OUT_V, PAR_ERR, STP_ERR, BRK_DET}), 32'(e.flags));
                check_eq("data", 32'(RX_OUT_P), 32'(e.data));
                if (e.lat > 0) check_eq("latency", cyc - e.e0, e.lat);
            end
        end
    end

    task automatic line_hold(input logic v, input int cycles);
        RX_IN_S = v;
        repeat (cycles) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int n, input int p,
                              input bit par_en, input bit par_bit, input bit stop1,
                              input bit stop2_en, input bit stop2, input bit flip,
                              input logic [3:0] flags, input int lat);
        logic [15:0] bits;
        int          nb;
        int          mask;
        exp_t        e;
        bits = '0;
        nb   = 1;
        for (int i = 0; i < n; i++) begin
            bits[nb] = d[i];
            nb++;
        end
        if (par_en) begin
            bits[nb] = par_bit;
            nb++;
        end
        bits[nb] = stop1;
        nb++;
        if (stop2_en) begin
            bits[nb] = stop2;
            nb++;
        end
        mask    = (1 << n) - 1;
        e.flags = flags;
        e.data  = d & DW'(mask);
        e.e0    = cyc + 1;
        e.lat   = lat;
        if (flags != 4'b0000) exp_q.push_back(e);
        for (int b = 0; b < nb; b++) begin
            for (int o = 0; o < p; o++) begin
                // Offset p/2 of each data bit is what the first vote sample sees.
                RX_IN_S = bits[b] ^ (flip && b >= 1 && b <= n && o == p / 2);
                @(posedge CLK);
                #1;
            end
        end
        line_hold(1'b1, 2 * p);
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check_eq("drain", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_out_p", 32'(RX_OUT_P), 0);
        check_eq("rst_pulses", 32'({RX_OUT_V, PAR_ERR, STP_ERR, BRK_DET}), 0);
        check_eq("rst_busy", 32'(BUSY), 0);
        RST = 1'b0;
        line_hold(1'b1, 4);
        check_eq("idle_busy", 32'(BUSY), 0);

        // Basic 8N1 frame with latency check.
        send_frame(9'h0A5, 8, 8, 0, 0, 1, 0, 0, 0, 4'b1000, 81);
        wait_drain(50);

        // 7 data bits, odd parity: good then bad parity bit.
        PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_LEN = 4'd7;
        send_frame(9'h055, 7, 8, 1, 1, 1, 0, 0, 0, 4'b1000, 81);
        wait_drain(50);
        send_frame(9'h055, 7, 8, 1, 0, 1, 0, 0, 0, 4'b0100, 81);
        wait_drain(50);
        PAR_EN = 1'b0; PAR_TYP = 1'b0;

        // 9 data bits, two stop bits, P = 16: bad second stop, then good frame.
        Prescale = 6'd16; DATA_LEN = 4'd9; STOP2 = 1'b1;
        send_frame(9'h1FF, 9, 16, 0, 0, 1, 1, 0, 0, 4'b0010, 189);
        wait_drain(50);
        send_frame(9'h003, 9, 16, 0, 0, 1, 1, 1, 0, 4'b1000, 189);
        wait_drain(50);
        STOP2 = 1'b0; Prescale = 6'd8; DATA_LEN = 4'd8;

        // Break: line low for 15 bit periods.
        begin
            exp_t e;
            e.flags = 4'b0001; e.data = '0; e.e0 = 0; e.lat = 0;
            exp_q.push_back(e);
        end
        line_hold(1'b0, 120);
        check_eq("brk_busy_low", 32'(BUSY), 1);
        line_hold(1'b1, 4);
        check_eq("brk_busy_high", 32'(BUSY), 0);
        wait_drain(10);
        send_frame(9'h03C, 8, 8, 0, 0, 1, 0, 0, 0, 4'b1000, 81);
        wait_drain(50);

        // Two-cycle glitch on an idle line.
        line_hold(1'b0, 2);
        line_hold(1'b1, 1);
        check_eq("glitch_busy_start", 32'(BUSY), 1);
        line_hold(1'b1, 16);
        check_eq("glitch_busy_end", 32'(BUSY), 0);

        // One flipped vote sample per data bit.
        send_frame(9'h0C3, 8, 8, 0, 0, 1, 0, 0, 1, 4'b1000, 81);
        wait_drain(50);

        // Reset in the middle of the data bits.
        line_hold(1'b0, 8);
        line_hold(1'b1, 24);
        RST = 1'b1;
        RX_IN_S = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("midrst_out_p", 32'(RX_OUT_P), 0);
        check_eq("midrst_pulses", 32'({RX_OUT_V, PAR_ERR, STP_ERR, BRK_DET}), 0);
        check_eq("midrst_busy", 32'(BUSY), 0);
        RST = 1'b0;
        line_hold(1'b1, 100);
        check_eq("midrst_idle", 32'(BUSY), 0);

        // DATA_LEN changed mid-frame is ignored.
        fork
            send_frame(9'h0B6, 8, 8, 0, 0, 1, 0, 0, 0, 4'b1000, 81);
            begin
                repeat (30) @(posedge CLK);
                #1;
                DATA_LEN = 4'd5;
            end
        join
        wait_drain(50);

        // Clamping: DATA_LEN 3 -> 5 and Prescale 2 -> 4; DATA_LEN 15 -> 9.
        DATA_LEN = 4'd3; Prescale = 6'd2;
        send_frame(9'h015, 5, 4, 0, 0, 1, 0, 0, 0, 4'b1000, 31);
        wait_drain(50);
        DATA_LEN = 4'd15; Prescale = 6'd8;
        send_frame(9'h155, 9, 8, 0, 0, 1, 0, 0, 0, 4'b1000, 89);
        wait_drain(50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver. It is the next-generation RX path for the UART top. It adds variable data length, optional second stop bit, 3-sample majority voting, and per-frame error and break reporting. It runs from a single oversampling clock and delivers a parallel word plus one-cycle status pulses to the downstream consumer.

Parameters:
DATA_W, 9, maximum data bits per frame; RX_OUT_P width.
PRESCALE_W, 6, width of Prescale.

Ports:
CLK  input  1  oversampling clock.
RST  input  1  synchronous reset, active-high.
RX_IN_S  input  1  serial line; idle high; asynchronous to CLK.
PAR_EN  input  1  1 = parity bit present.
PAR_TYP  input  1  0 = even, 1 = odd.
STOP2  input  1  1 = two stop bits checked.
DATA_LEN  input  4  data bits per frame; legal range 5..DATA_W.
Prescale  input  PRESCALE_W  CLK cycles per bit; legal minimum 4.
RX_OUT_P  output  DATA_W  received word, LSB = first bit on the line; bits at or above DATA_LEN are 0.
RX_OUT_V  output  1  one-cycle pulse: good frame on RX_OUT_P.
PAR_ERR  output  1  one-cycle pulse: parity mismatch.
STP_ERR  output  1  one-cycle pulse: stop bit sampled 0 (not a break).
BRK_DET  output  1  one-cycle pulse: break frame.
BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, both synchroniser flops preset to 1 so no false start. Reset mid-frame aborts the frame silently; no pulse is emitted.
- Synchroniser: RX_IN_S passes through a 2-flop synchroniser; all logic uses the synchronised copy (rxs).
- Configuration capture:
  - PAR_EN, PAR_TYP, STOP2, DATA_LEN and Prescale are latched on the IDLE->START transition. Changes mid-frame are ignored.
  - DATA_LEN below 5 is treated as 5; above DATA_W it is treated as DATA_W.
  - Prescale below 4 is treated as 4.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE -> START when rxs = 0. The bit counter cnt is cleared; cnt counts 0..P-1 within each bit.
  - Each bit is sampled at cnt = P/2-1, P/2 and P/2+1 (P/2 uses floor). The bit value is the majority of the three samples, decided at cnt = P/2+1.
  - START: if the majority is 1, the start was a glitch; go to IDLE with no pulse. Otherwise at cnt = P-1 go to DATA.
  - DATA: shift LSB first for DATA_LEN bits. Then go to PARITY if PAR_EN, else STOP1.
  - PARITY: compute the expected bit as XOR of the data bits XOR PAR_TYP. A mismatch sets an internal parity-error flag.
  - STOP1: if STOP2 is latched, run the full bit and go to STOP2. Otherwise finish the frame at the decision point.
  - STOP2: finish the frame at its decision point. A 0 in either stop bit sets the stop-error flag.
- Frame finish: in the cycle after the final decision, RX_OUT_P is updated and exactly one outcome is reported. The FSM returns to IDLE without waiting for the end of the stop bit, so back-to-back frames resync on the next falling edge.
  - Break: all data bits, the parity bit if present, and all stop bits are 0. Pulse BRK_DET only; RX_OUT_V, PAR_ERR and STP_ERR stay 0. Go to WAIT_HIGH.
  - Otherwise, if either error flag is set: pulse PAR_ERR and/or STP_ERR; RX_OUT_V stays 0.
  - Otherwise: pulse RX_OUT_V.
- WAIT_HIGH: stay until rxs = 1, then go to IDLE. No start detection occurs while in this state.
- Latency: let E0 be the first CLK edge that samples RX_IN_S low. RX_OUT_V (or the error pulse) is high in the cycle after edge E0 + L, where L = 3 + (1 + N + PAR_EN + STOP2)*P + P/2 + 2. For P = 8, N = 8, no parity, one stop bit, L = 81.
- Arithmetic: cnt is PRESCALE_W bits; the data bit index is clog2(DATA_W+1) bits. No wrap is possible within legal ranges.

Test Plan:
- P = 8, N = 8, PAR_EN = 0, STOP2 = 0; send 0xA5 -> RX_OUT_V pulses exactly once, 81 cycles after E0, with RX_OUT_P = 0x0A5. PAR_ERR, STP_ERR and BRK_DET stay 0.
- P = 8, N = 7, PAR_EN = 1, PAR_TYP = 1; send 0x55 with the correct parity bit 1, then 0x55 with the parity bit forced to 0 -> first frame gives RX_OUT_V with RX_OUT_P = 0x055; second frame gives PAR_ERR and no RX_OUT_V.
- P = 16, N = 9, STOP2 = 1; send 0x1FF with the second stop bit forced to 0 -> STP_ERR pulses once and RX_OUT_P = 0x1FF. A following correct 0x003 frame gives RX_OUT_V with RX_OUT_P = 0x003.
- Hold RX_IN_S low for 15 bit periods at P = 8, N = 8 -> a single BRK_DET pulse and BUSY stays high until the line returns high. The next 0x3C frame is then received correctly.
- Glitches and majority voting at P = 8:
  - 2-cycle low glitch on an idle line -> no pulse of any kind; BUSY falls back to 0.
  - One flipped sample per data bit (the cnt = P/2-1 sample) on 0xC3 -> RX_OUT_V with RX_OUT_P = 0x0C3.
- Assert RST for 1 cycle mid-DATA -> all outputs 0 on the next cycle and no pulse for the aborted frame. Change DATA_LEN from 8 to 5 mid-frame -> the current frame still decodes as 8 bits.
